// File: rtl/store_write_buffer_if.sv
// Bus bundle for store_write_buffer: core store port, memory drain channel,
// load-forwarding lookup and occupancy. The buffer takes the slave side.
interface store_write_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              MemWrite;
    logic [ADDR_W-1:0] DataAdr;
    logic [DATA_W-1:0] WriteData;
    logic              StoreStall;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_data;

    logic [CNT_W-1:0]  count;

    modport master (
        output MemWrite, DataAdr, WriteData, mem_ready, rd_addr,
        input  StoreStall, mem_valid, mem_addr, mem_wdata, rd_hit, rd_data, count
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, mem_ready, rd_addr,
        output StoreStall, mem_valid, mem_addr, mem_wdata, rd_hit, rd_data, count
    );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the core store port and data memory, with
// youngest-entry store-to-load forwarding. Optional: STORE_WB_COALESCE_EN.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_coalesce;
    logic              w_hit;
    logic [DATA_W-1:0] w_rd_data;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && bus.mem_ready;

`ifdef STORE_WB_COALESCE_EN
    logic [PTR_W-1:0] w_youngest;
    assign w_youngest = r_tail - PTR_W'(1);
    // The youngest entry cannot absorb a store on the edge it leaves as head.
    assign w_coalesce = bus.MemWrite && !w_empty
                     && ((bus.DataAdr >> 2) == (r_addr_mem[w_youngest] >> 2))
                     && !((r_count == CNT_W'(1)) && w_pop);
`else
    assign w_coalesce = 1'b0;
`endif

    // Space freed by a same-cycle pop is not reused until the next cycle.
    assign w_push         = bus.MemWrite && !w_full && !w_coalesce;
    assign bus.StoreStall = bus.MemWrite && w_full && !w_coalesce;

    assign bus.mem_valid = !w_empty;
    assign bus.mem_addr  = w_empty ? '0 : r_addr_mem[r_head];
    assign bus.mem_wdata = w_empty ? '0 : r_data_mem[r_head];
    assign bus.count     = r_count;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, regardless of block ordering in simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the entry storage is deliberately not reset; occupancy and the
    // pointers decide what is visible, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_tail] <= bus.DataAdr;
            r_data_mem[r_tail] <= bus.WriteData;
        end
`ifdef STORE_WB_COALESCE_EN
        else if (w_coalesce) begin
            r_data_mem[w_youngest] <= bus.WriteData;
        end
`endif
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_hit     = 1'b0;
        w_rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count)
                && ((bus.rd_addr >> 2) == (r_addr_mem[r_head + PTR_W'(k)] >> 2))) begin
                w_hit     = 1'b1;
                w_rd_data = r_data_mem[r_head + PTR_W'(k)];
            end
        end
    end

    assign bus.rd_hit  = w_hit;
    assign bus.rd_data = w_rd_data;
endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus random
// traffic, compared against a queue-based model of the buffer contents.
module tb_store_write_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic clk;
    logic reset;

    store_write_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     n_total = 0;
    int     n_bad   = 0;
    entry_t q[$];
    entry_t drain_log[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, compare outputs against the
    // model, then advance the model by what the rising edge must do.
    task automatic step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic [31:0] ra, input logic rst,
                        output logic accepted);
        logic        full, pop, coal, exp_hit;
        logic [31:0] exp_rd;
        entry_t      e;
        bus.MemWrite  = wr;
        bus.DataAdr   = a;
        bus.WriteData = d;
        bus.mem_ready = rdy;
        bus.rd_addr   = ra;
        reset         = rst;
        #1;
        full = (q.size() == DEPTH);
        pop  = (q.size() != 0) && rdy;
        coal = 1'b0;
`ifdef STORE_WB_COALESCE_EN
        if (wr && q.size() != 0 && ((q[$].addr >> 2) == (a >> 2)) && !(q.size() == 1 && pop))
            coal = 1'b1;
`endif
        exp_hit = 1'b0;
        exp_rd  = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!exp_hit && ((q[i].addr >> 2) == (ra >> 2))) begin
                exp_hit = 1'b1;
                exp_rd  = q[i].data;
            end
        end
        check("stall",     bus.StoreStall, wr && full && !coal);
        check("mem_valid", bus.mem_valid,  q.size() != 0);
        check("mem_addr",  bus.mem_addr,   (q.size() != 0) ? q[0].addr : 32'h0);
        check("mem_wdata", bus.mem_wdata,  (q.size() != 0) ? q[0].data : 32'h0);
        check("rd_hit",    bus.rd_hit,     exp_hit);
        check("rd_data",   bus.rd_data,    exp_rd);
        check("count",     bus.count,      q.size());
        accepted = wr && (coal || !full);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (coal) begin
                q[$].data = d;
            end else if (wr && !full) begin
                e.addr = a;
                e.data = d;
                q.push_back(e);
            end
            if (pop) begin
                drain_log.push_back(q[0]);
                void'(q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        step(1'b0, 32'h0, 32'h0, rdy, 32'hFFFF_FFF0, 1'b0, acc);
    endtask

    // Core holds its store until accepted; ready toggles when asked to.
    task automatic store_hold(input logic [31:0] a, input logic [31:0] d,
                              input logic rdy, input logic toggle);
        logic acc;
        logic r;
        int   tries;
        acc   = 1'b0;
        r     = rdy;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, a, d, r, a, 1'b0, acc);
            if (toggle) r = ~r;
            tries++;
        end
        if (!acc) check("store_hold_timeout", 1, 0);
    endtask

    task automatic drain();
        int tries;
        tries = 0;
        while (q.size() != 0 && tries < 40) begin
            idle(1'b1);
            tries++;
        end
        check("drain_count", bus.count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        bus.mem_ready = 1'b0;
        bus.rd_addr   = '0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_count",  bus.count,      0);
        check("reset_valid",  bus.mem_valid,  0);
        check("reset_addr",   bus.mem_addr,   0);
        check("reset_wdata",  bus.mem_wdata,  0);
        check("reset_hit",    bus.rd_hit,     0);
        check("reset_rddata", bus.rd_data,    0);
        check("reset_stall",  bus.StoreStall, 0);

        // Single store, one-cycle latency to the memory side, pops immediately.
        step(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, acc);
        check("t1_valid", bus.mem_valid, 1);
        check("t1_addr",  bus.mem_addr,  32'h100);
        check("t1_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        idle(1'b1);
        check("t1_count", bus.count, 0);

        // Fill to DEPTH, stall the fifth store, then drain in order.
        drain_log.delete();
        for (int i = 0; i < 4; i++) store_hold(32'(4 * i), 32'(32'hA0 + i), 1'b0, 1'b0);
        check("t2_full", bus.count, 4);
        step(1'b1, 32'h10, 32'hA4, 1'b0, 32'h10, 1'b0, acc);
        check("t2_stall", bus.StoreStall, 1);
        store_hold(32'h10, 32'hA4, 1'b1, 1'b0);
        drain();
        check("t2_ndrain", drain_log.size(), 5);
        for (int i = 0; i < 5 && i < drain_log.size(); i++)
            check("t2_order", drain_log[i].addr, 32'(4 * i));

        // Forwarding of the youngest matching store, word-granular compare.
        store_hold(32'h20, 32'h11, 1'b0, 1'b0);
        store_hold(32'h20, 32'h22, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h22, 1'b0, acc);
        check("t3_hit",  bus.rd_hit,  1);
        check("t3_data", bus.rd_data, 32'h22);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h24, 1'b0, acc);
        check("t3_miss",      bus.rd_hit,  0);
        check("t3_miss_data", bus.rd_data, 0);
        drain();

        // Ten stores with toggling ready: wrap, order, no loss or duplication.
        drain_log.delete();
        for (int i = 0; i < 10; i++) store_hold(32'(32'h200 + 4 * i), 32'(32'hC00 + i), i[0], 1'b1);
        drain();
        check("t4_ndrain", drain_log.size(), 10);
        for (int i = 0; i < 10 && i < drain_log.size(); i++) begin
            check("t4_addr", drain_log[i].addr, 32'(32'h200 + 4 * i));
            check("t4_data", drain_log[i].data, 32'(32'hC00 + i));
        end

        // Reset with three stores pending discards them.
        for (int i = 0; i < 3; i++) store_hold(32'(32'h300 + 4 * i), 32'(i + 1), 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h304, 1'b1, acc);
        check("t5_count", bus.count,     0);
        check("t5_valid", bus.mem_valid, 0);
        check("t5_hit",   bus.rd_hit,    0);
        drain_log.delete();
        store_hold(32'h40, 32'h4040, 1'b0, 1'b0);
        drain();
        check("t5_ndrain", drain_log.size(), 1);
        if (drain_log.size() > 0) check("t5_addr", drain_log[0].addr, 32'h40);

`ifdef STORE_WB_COALESCE_EN
        drain_log.delete();
        store_hold(32'h80, 32'h1, 1'b0, 1'b0);
        store_hold(32'h84, 32'h2, 1'b0, 1'b0);
        store_hold(32'h84, 32'h3, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h84, 1'b0, acc);
        check("t6_count", bus.count,   2);
        check("t6_data",  bus.rd_data, 32'h3);
        drain();
        check("t6_ndrain", drain_log.size(), 2);
`endif

        // Random traffic on a small address pool to exercise hits and wrap.
        for (int n = 0; n < 500; n++) begin
            logic        wr, rdy, rst;
            logic [31:0] a, ra;
            wr  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 49) == 0);
            a   = {26'h0, 3'($urandom_range(0, 7)), 1'b0, 2'($urandom)};
            ra  = {26'h0, 3'($urandom_range(0, 7)), 1'b0, 2'($urandom)};
            step(wr, a, $urandom, rdy, ra, rst, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
